regras_intervalo: RTL and testbench
===================================

REGRAS_INTERVALO -- requirements
Module: regras_intervalo

Interface
REQ-001 The block SHALL have these ports (clock and reset first), one clock domain, reset asynchronous and active-high:
- CLK  input  1  rising-edge clock
- RESET  input  1  asynchronous, active-high reset
- Start  input  1  single-cycle request to evaluate one snapshot of the FOU outputs
- FOU_01_UP..FOU_06_UP  input  8 each  upper memberships; 01..03 = Input_01 MF1..MF3, 04..06 = Input_02 MF1..MF3
- FOU_01_LOW..FOU_06_LOW  input  8 each  lower memberships, same mapping
- Ativo_UP  input  6  bit n-1 = 1 when FOU_0n_UP is nonzero
- Busy  output  1  evaluation in progress
- Rule_Valid  output  1  Rule_Idx/F_UP/F_LOW valid this cycle
- Rule_Idx  output  4  rule number k = 3*i + j, with i = Input_01 MF (0..2) and j = Input_02 MF (0..2)
- F_UP  output  8  upper firing strength of rule k
- F_LOW  output  8  lower firing strength of rule k
- Done  output  1  one-cycle pulse after the last rule of a snapshot

Function
REQ-002 The FSM SHALL have three states: IDLE, EVAL and DONE.
REQ-003 In IDLE, a rising edge with Start=1 SHALL register all 12 FOU inputs and Ativo_UP into a snapshot, set the rule counter to the first rule to evaluate, and move to EVAL.
REQ-004 Start SHALL be ignored in EVAL and DONE; the snapshot SHALL NOT change until the next accepted Start.
REQ-005 In EVAL, each rising edge SHALL register one rule and advance the counter:
- Rule_Valid = 1
- Rule_Idx = k
- F_UP = min(FOU_(i+1)_UP, FOU_(j+4)_UP)
- F_LOW = min(FOU_(i+1)_LOW, FOU_(j+4)_LOW)
REQ-006 Arithmetic SHALL be an unsigned 8-bit compare with no scaling or clamping; when F_LOW > F_UP, both values SHALL be passed through unchanged.
REQ-007 After the edge that presents the last rule, the FSM SHALL go to DONE; in DONE, Rule_Valid = 0 and Done = 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-008 Busy SHALL be 1 in EVAL and DONE and 0 in IDLE.
REQ-009 Latency: with Start accepted at edge t, the first rule SHALL be output after edge t+1; for N rules evaluated, Done SHALL be high after edge t+N+1.
REQ-010 Start may be asserted in the same cycle that Done is high; it SHALL be sampled only once the FSM is in IDLE, so the earliest accepted Start is at the edge after DONE.
REQ-011 Outside EVAL, Rule_Valid SHALL be 0 and Rule_Idx, F_UP and F_LOW SHALL hold their last values.

Reset
REQ-012 RESET=1 SHALL immediately clear all outputs, the snapshot and the counter to 0, set the FSM to IDLE, and hold that state while asserted.
REQ-013 A RESET asserted during EVAL SHALL abort the evaluation with no Done pulse; the first Start after release SHALL begin a fresh evaluation from the first rule.

Configuration
REQ-014 Macro REGRAS_SKIP_INACTIVE_EN SHALL select rule skipping:
- Undefined: all 9 rules k = 0..8 SHALL be evaluated in ascending order, N = 9, regardless of Ativo_UP.
- Defined: only rules with snapshot Ativo_UP[i] = 1 and Ativo_UP[3+j] = 1 SHALL be evaluated, in ascending k, one per cycle, with no idle cycles between them (next-active priority select).
- Defined, no active rule: the FSM SHALL go from IDLE directly to DONE and Done SHALL be high after edge t+1.

Verification
REQ-015 The bench SHALL cover these directed scenarios:
- Reset: RESET=1 mid-EVAL at rule 4 -> all outputs read 0 immediately; no Done; a subsequent Start restarts at Rule_Idx=0.
- Basic, macro undefined: FOU_01_UP=200, FOU_04_UP=120, FOU_01_LOW=90, FOU_04_LOW=150, all others 0, Start at edge t -> Rule_Idx=0, F_UP=120, F_LOW=90 after edge t+1; rules 1..8 give F_UP=F_LOW=0; Done after edge t+10.
- Skip, macro defined: Ativo_UP=6'b011_010 (MF2 of Input_01; MF1 and MF2 of Input_02) -> only Rule_Idx 3 and 4, on consecutive cycles; Done after edge t+3.
- Empty, macro defined: Ativo_UP=0, Start -> Done after edge t+1; Rule_Valid never 1.
- Snapshot hold: change every FOU input to 255 during EVAL -> remaining outputs still reflect the captured values; Start pulses during EVAL are ignored.
- Back-to-back: Start held high continuously -> a new evaluation is accepted at the edge after DONE, and every rule sequence is complete and in order.

Source files
------------

// File: rtl/regras_intervalo.sv
// ---------------------------------------------------------------------------
// regras_intervalo
//
// Purpose: rule-firing stage of a two-input interval type-2 fuzzy system.
// On Start, a snapshot of the six upper/lower membership grades is taken.
// One rule per cycle is then presented. Rule k = 3*i + j pairs Input_01
// MF(i) with Input_02 MF(j). Its strengths are the unsigned minimum of the
// two upper grades and, separately, of the two lower grades. Done pulses
// once after the last rule.
//
// Configuration macro: REGRAS_SKIP_INACTIVE_EN
//   undefined : all nine rules are evaluated, Ativo_UP is ignored
//   defined   : only rules whose two antecedents are flagged active in the
//               snapshot of Ativo_UP are evaluated, back to back
//
// Ports:
//   CLK, RESET             rising-edge clock, asynchronous active-high reset
//   Start                  request to evaluate one snapshot (sampled in IDLE)
//   FOU_0n_UP/FOU_0n_LOW   upper/lower grades; 01..03 Input_01, 04..06 Input_02
//   Ativo_UP               bit n-1 set when FOU_0n_UP is nonzero
//   Busy                   FSM is in EVAL or DONE
//   Rule_Valid             Rule_Idx/F_UP/F_LOW carry a rule this cycle
//   Rule_Idx, F_UP, F_LOW  rule number and its upper/lower firing strength
//   Done                   one-cycle pulse after the last rule
// ---------------------------------------------------------------------------
module regras_intervalo (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       Start,
    input  logic [7:0] FOU_01_UP,
    input  logic [7:0] FOU_02_UP,
    input  logic [7:0] FOU_03_UP,
    input  logic [7:0] FOU_04_UP,
    input  logic [7:0] FOU_05_UP,
    input  logic [7:0] FOU_06_UP,
    input  logic [7:0] FOU_01_LOW,
    input  logic [7:0] FOU_02_LOW,
    input  logic [7:0] FOU_03_LOW,
    input  logic [7:0] FOU_04_LOW,
    input  logic [7:0] FOU_05_LOW,
    input  logic [7:0] FOU_06_LOW,
    input  logic [5:0] Ativo_UP,
    output logic       Busy,
    output logic       Rule_Valid,
    output logic [3:0] Rule_Idx,
    output logic [7:0] F_UP,
    output logic [7:0] F_LOW,
    output logic       Done
);

    typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

    state_t     state_q;
    logic [3:0] k_q;            // rule to present at the next EVAL edge
    logic [5:0] ativo_q;
    logic [7:0] up_q  [6];
    logic [7:0] low_q [6];

    // Lowest rule index >= from whose mask bit is set; bit 4 = found.
    function automatic logic [4:0] next_rule(input logic [8:0] mask,
                                             input logic [3:0] from);
        logic [4:0] r;
        r = '0;
        for (int n = 8; n >= 0; n--) begin
            if (mask[n] && (4'(n) >= from)) r = {1'b1, 4'(n)};
        end
        return r;
    endfunction

    // Rule-enable masks: one from the live input (used when accepting
    // Start), one from the snapshot (used while stepping through rules).
    logic [8:0] mask_in, mask_q;

`ifdef REGRAS_SKIP_INACTIVE_EN
    always_comb begin
        mask_in = '0;
        mask_q  = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                mask_in[3*i+j] = Ativo_UP[i] & Ativo_UP[3+j];
                mask_q[3*i+j]  = ativo_q[i]  & ativo_q[3+j];
            end
        end
    end
`else
    assign mask_in = '1;
    assign mask_q  = '1;
    // Activity flags are still captured but have no effect in this build.
    logic unused_ativo;
    assign unused_ativo = ^{Ativo_UP, ativo_q};
`endif

    logic [4:0] first_d;        // first rule of a new snapshot
    logic [4:0] next_d;         // rule following k_q in the snapshot
    assign first_d = next_rule(mask_in, 4'd0);
    assign next_d  = next_rule(mask_q, k_q + 4'd1);

    // Split k into (i, j) and fetch the two antecedent grades.
    logic [1:0] sel_i, sel_j;
    logic [7:0] up_a, up_b, low_a, low_b;
    logic [7:0] f_up_d, f_low_d;

    always_comb begin
        if (k_q >= 4'd6) begin
            sel_i = 2'd2;
            sel_j = 2'(k_q - 4'd6);
        end else if (k_q >= 4'd3) begin
            sel_i = 2'd1;
            sel_j = 2'(k_q - 4'd3);
        end else begin
            sel_i = 2'd0;
            sel_j = 2'(k_q);
        end
        up_a  = up_q[{1'b0, sel_i}];
        low_a = low_q[{1'b0, sel_i}];
        up_b  = up_q[3'd3 + {1'b0, sel_j}];
        low_b = low_q[3'd3 + {1'b0, sel_j}];
        // Upper and lower paths are independent; F_LOW > F_UP passes through.
        f_up_d  = (up_a  < up_b ) ? up_a  : up_b;
        f_low_d = (low_a < low_b) ? low_a : low_b;
    end

    assign Busy = (state_q != IDLE);

    // NOTE: every register below is assigned with <= so all of them update
    // from the same pre-edge values; blocking assignments here would let
    // later statements see already-updated state.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            k_q        <= '0;
            ativo_q    <= '0;
            // NOTE: the snapshot is tiny register storage, not RAM, so it is
            // cleared on reset like any other state.
            for (int n = 0; n < 6; n++) begin
                up_q[n]  <= '0;
                low_q[n] <= '0;
            end
            Rule_Valid <= 1'b0;
            Rule_Idx   <= '0;
            F_UP       <= '0;
            F_LOW      <= '0;
            Done       <= 1'b0;
        end else begin
            Rule_Valid <= 1'b0;
            Done       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        up_q[0]  <= FOU_01_UP;
                        up_q[1]  <= FOU_02_UP;
                        up_q[2]  <= FOU_03_UP;
                        up_q[3]  <= FOU_04_UP;
                        up_q[4]  <= FOU_05_UP;
                        up_q[5]  <= FOU_06_UP;
                        low_q[0] <= FOU_01_LOW;
                        low_q[1] <= FOU_02_LOW;
                        low_q[2] <= FOU_03_LOW;
                        low_q[3] <= FOU_04_LOW;
                        low_q[4] <= FOU_05_LOW;
                        low_q[5] <= FOU_06_LOW;
                        ativo_q  <= Ativo_UP;
                        k_q      <= first_d[3:0];
                        // With nothing to evaluate, go straight to the Done pulse.
                        state_q  <= first_d[4] ? EVAL : DONE;
                    end
                end
                EVAL: begin
                    Rule_Valid <= 1'b1;
                    Rule_Idx   <= k_q;
                    F_UP       <= f_up_d;
                    F_LOW      <= f_low_d;
                    if (next_d[4]) begin
                        k_q <= next_d[3:0];
                    end else begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    Done    <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regras_intervalo.sv
// ---------------------------------------------------------------------------
// tb_regras_intervalo
//
// Directed bench for regras_intervalo. A transaction-level model keeps the
// list of rules still to be presented for the current snapshot; a compare
// process checks every DUT output against it on each falling edge. Directed
// scenarios add hand-computed literal checks at exact edges after Start.
// Build with +define+REGRAS_SKIP_INACTIVE_EN to exercise rule skipping.
// ---------------------------------------------------------------------------
module tb_regras_intervalo;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] fu [6];
    logic [7:0] fl [6];
    logic [5:0] ativo = '0;

    logic       busy, rule_valid, done;
    logic [3:0] rule_idx;
    logic [7:0] f_up, f_low;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regras_intervalo dut (
        .CLK        (clk),
        .RESET      (rst),
        .Start      (start),
        .FOU_01_UP  (fu[0]),
        .FOU_02_UP  (fu[1]),
        .FOU_03_UP  (fu[2]),
        .FOU_04_UP  (fu[3]),
        .FOU_05_UP  (fu[4]),
        .FOU_06_UP  (fu[5]),
        .FOU_01_LOW (fl[0]),
        .FOU_02_LOW (fl[1]),
        .FOU_03_LOW (fl[2]),
        .FOU_04_LOW (fl[3]),
        .FOU_05_LOW (fl[4]),
        .FOU_06_LOW (fl[5]),
        .Ativo_UP   (ativo),
        .Busy       (busy),
        .Rule_Valid (rule_valid),
        .Rule_Idx   (rule_idx),
        .F_UP       (f_up),
        .F_LOW      (f_low),
        .Done       (done)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] min8(input logic [7:0] a, input logic [7:0] b);
        return (a < b) ? a : b;
    endfunction

    // ------------------------------------------------------------------
    // Reference model: on an accepted Start, list every enabled rule with
    // its strengths; then emit one per edge, then one Done edge.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [3:0] idx;
        logic [7:0] fu;
        logic [7:0] fl;
    } rule_t;

    rule_t      m_q [$];
    rule_t      m_r;
    logic       m_busy = 1'b0;
    logic       m_done_pend = 1'b0;
    logic       e_valid = 1'b0;
    logic       e_done  = 1'b0;
    logic [3:0] e_idx   = '0;
    logic [7:0] e_fu    = '0;
    logic [7:0] e_fl    = '0;

    function automatic logic rule_enabled(input logic [5:0] a, input int i, input int j);
`ifdef REGRAS_SKIP_INACTIVE_EN
        return a[i] && a[3+j];
`else
        return (a == a) || (i + j >= 0);
`endif
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_q.delete();
                m_busy = 1'b0; m_done_pend = 1'b0;
                e_valid = 1'b0; e_done = 1'b0;
                e_idx = '0; e_fu = '0; e_fl = '0;
            end else begin
                e_valid = 1'b0;
                e_done  = 1'b0;
                if (!m_busy) begin
                    if (start) begin
                        m_busy = 1'b1;
                        for (int i = 0; i < 3; i++)
                            for (int j = 0; j < 3; j++)
                                if (rule_enabled(ativo, i, j))
                                    m_q.push_back('{idx: 4'(3*i+j),
                                                    fu: min8(fu[i], fu[3+j]),
                                                    fl: min8(fl[i], fl[3+j])});
                        if (m_q.size() == 0) m_done_pend = 1'b1;
                    end
                end else if (m_q.size() != 0) begin
                    m_r = m_q.pop_front();
                    e_valid = 1'b1;
                    e_idx = m_r.idx; e_fu = m_r.fu; e_fl = m_r.fl;
                    if (m_q.size() == 0) m_done_pend = 1'b1;
                end else if (m_done_pend) begin
                    e_done = 1'b1;
                    m_done_pend = 1'b0;
                    m_busy = 1'b0;
                end
            end
        end
    end

    // Compare process: every output, every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            check("busy",       32'(busy),       32'(m_busy));
            check("rule_valid", 32'(rule_valid), 32'(e_valid));
            check("rule_idx",   32'(rule_idx),   32'(e_idx));
            check("f_up",       32'(f_up),       32'(e_fu));
            check("f_low",      32'(f_low),      32'(e_fl));
            check("done",       32'(done),       32'(e_done));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic set_inputs(input logic [7:0] base_up, input logic [7:0] base_low);
        for (int n = 0; n < 6; n++) begin
            fu[n] = 8'(base_up  * (n + 1));
            fl[n] = 8'(base_low * (n + 1));
        end
    endtask

    // Returns just after edge t, the edge at which Start is sampled.
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        logic got;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(posedge clk);
            #1 if (done) got = 1'b1;
        end
        check(name, 32'(got), 32'd1);
    endtask

    // ------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------
    initial begin
        logic seen;
        set_inputs(8'd0, 8'd0);
        #1 rst = 1'b1;
        #2;
        check("reset_busy",  32'(busy), 32'd0);
        check("reset_valid", 32'(rule_valid), 32'd0);
        check("reset_done",  32'(done), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // Basic: only rule 0 is nonzero; F_LOW comes from the lower pair.
        set_inputs(8'd0, 8'd0);
        fu[0] = 8'd200; fu[3] = 8'd120; fl[0] = 8'd90; fl[3] = 8'd150;
        ativo = 6'b111_111;
        pulse_start();
        @(posedge clk); #1;
        check("basic_t1_valid", 32'(rule_valid), 32'd1);
        check("basic_t1_idx",   32'(rule_idx),   32'd0);
        check("basic_t1_fup",   32'(f_up),       32'd120);
        check("basic_t1_flow",  32'(f_low),      32'd90);
        for (int c = 2; c <= 10; c++) begin
            @(posedge clk); #1;
            if (c == 9)  check("basic_t9_idx",   32'(rule_idx), 32'd8);
            if (c == 9)  check("basic_t9_fup",   32'(f_up),     32'd0);
            if (c == 9)  check("basic_t9_done",  32'(done),     32'd0);
            if (c == 10) check("basic_t10_done", 32'(done),     32'd1);
            if (c == 10) check("basic_t10_valid", 32'(rule_valid), 32'd0);
        end
        @(posedge clk); #1;
        check("basic_done_width", 32'(done), 32'd0);

        // Reset during EVAL at rule 4: outputs clear at once, no Done.
        set_inputs(8'd10, 8'd5);
        ativo = 6'b111_111;
        pulse_start();
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge clk);
            #1 if (rule_valid && rule_idx == 4'd4) seen = 1'b1;
        end
        check("rst_reach_rule4", 32'(seen), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_idx",   32'(rule_idx),   32'd0);
        check("rst_async_fup",   32'(f_up),       32'd0);
        check("rst_async_flow",  32'(f_low),      32'd0);
        check("rst_async_valid", 32'(rule_valid), 32'd0);
        check("rst_async_busy",  32'(busy),       32'd0);
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1 if (done) seen = 1'b1;
        end
        check("rst_no_done", 32'(seen), 32'd0);
        pulse_start();
        @(posedge clk); #1;
        check("rst_restart_idx",   32'(rule_idx),   32'd0);
        check("rst_restart_valid", 32'(rule_valid), 32'd1);
        check("rst_restart_fup",   32'(f_up),       32'd10);
        wait_done("rst_restart_done");

`ifdef REGRAS_SKIP_INACTIVE_EN
        // Skip: Input_01 MF2 with Input_02 MF1/MF2 -> rules 3 and 4 only.
        set_inputs(8'd10, 8'd5);
        ativo = 6'b011_010;
        pulse_start();
        @(posedge clk); #1;
        check("skip_t1_idx",   32'(rule_idx),   32'd3);
        check("skip_t1_fup",   32'(f_up),       32'd20);
        check("skip_t1_flow",  32'(f_low),      32'd10);
        @(posedge clk); #1;
        check("skip_t2_idx",   32'(rule_idx),   32'd4);
        check("skip_t2_valid", 32'(rule_valid), 32'd1);
        @(posedge clk); #1;
        check("skip_t3_done",  32'(done),       32'd1);

        // Empty: nothing active -> Done right after edge t+1.
        @(posedge clk);
        ativo = 6'b000_000;
        pulse_start();
        @(posedge clk); #1;
        check("empty_t1_done",  32'(done),       32'd1);
        check("empty_t1_valid", 32'(rule_valid), 32'd0);
`else
        // All flags clear: every rule still runs when skipping is off.
        set_inputs(8'd3, 8'd7);
        ativo = 6'b000_000;
        pulse_start();
        @(posedge clk); #1;
        check("noskip_t1_valid", 32'(rule_valid), 32'd1);
        repeat (9) @(posedge clk);
        #1 check("noskip_t10_done", 32'(done), 32'd1);
`endif

        // Snapshot hold: inputs jump to 255 and Start pulses mid-EVAL.
        @(posedge clk);
        set_inputs(8'd10, 8'd5);
        ativo = 6'b111_111;
        pulse_start();
        repeat (3) @(posedge clk);
        #1;
        for (int n = 0; n < 6; n++) begin
            fu[n] = 8'd255;
            fl[n] = 8'd255;
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("hold_idx",  32'(rule_idx), 32'd3);
        check("hold_fup",  32'(f_up),     32'd20);
        check("hold_flow", 32'(f_low),    32'd10);
        wait_done("hold_done");
        @(posedge clk); #1;
        check("hold_no_restart", 32'(busy), 32'd0);

        // Back-to-back: Start held high; the edge after Done accepts.
        set_inputs(8'd7, 8'd11);
        fl[1] = 8'd200;                     // F_LOW above F_UP passes through
        @(negedge clk) start = 1'b1;
        wait_done("b2b_first_done");
        @(posedge clk); #1;
        check("b2b_accept_busy",  32'(busy),       32'd1);
        check("b2b_accept_valid", 32'(rule_valid), 32'd0);
        @(posedge clk); #1;
        check("b2b_second_idx",   32'(rule_idx),   32'd0);
        check("b2b_second_valid", 32'(rule_valid), 32'd1);
        repeat (14) @(posedge clk);
        #1 start = 1'b0;
        wait_done("b2b_last_done");
        repeat (3) @(posedge clk);
        #1 check("b2b_idle", 32'(busy), 32'd0);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
